uart_tx_stream: RTL and testbench

Serial UART transmitter with a VALID/READY byte input. It sits directly downstream of the register slice and consumes its `output_valid`/`output_ready`/`output_data` stream. It serialises each accepted byte onto a single TX pin as 8N1 (or 8E1/8O1). `input_ready` depends only on internal state, never combinationally on `input_valid`, so it may be chained behind any slice without creating combinational loops.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_stream_if.sv | 20 ++
 rtl/uart_baud_counter.sv | 42 ++++
 rtl/uart_tx_stream.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_stream.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// The parity feature is selected by the UART_TX_PARITY_EN macro in uart_tx_stream.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned UART_BIT_IDX_W = $clog2(UART_DATA_BITS);

    typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    // Bit period in clocks, truncated.
    function automatic int unsigned clks_per_bit(input int unsigned clock_hz,
                                                 input int unsigned baud);
        return clock_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_stream_if.sv
// VALID/READY byte stream feeding the UART transmitter.
interface uart_tx_stream_if;

    logic                  input_valid;
    logic                  input_ready;
    uart_pkg::uart_byte_t  input_data;

    modport master (
        output input_valid,
        output input_data,
        input  input_ready
    );

    modport slave (
        input  input_valid,
        input  input_data,
        output input_ready
    );

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period counter: tick marks the last clock of each bit period.
module uart_baud_counter #(
    parameter int unsigned CLKS_PER_BIT = 234
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tick = enable && (count_q == CNT_LAST);

    // Wraps on tick so successive bits stay exactly CLKS_PER_BIT apart.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            if (count_q == CNT_LAST) begin
                count_d = '0;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_stream.sv
// UART transmitter (8N1/8N2) with a VALID/READY byte input.
// Define UART_TX_PARITY_EN to insert an even/odd parity bit after the data bits.
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_HZ   = 27_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic             clock,
    input  logic             reset,
    uart_tx_stream_if.slave  in_if,
    output logic             txd,
    output logic             busy
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLOCK_HZ, BAUD_RATE);
    localparam logic [UART_BIT_IDX_W-1:0] DATA_LAST = UART_BIT_IDX_W'(UART_DATA_BITS - 1);
    localparam logic [UART_BIT_IDX_W-1:0] STOP_LAST = UART_BIT_IDX_W'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_stream: CLOCK_HZ / BAUD_RATE must be at least 2");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
        $error("uart_tx_stream: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("uart_tx_stream: PARITY_ODD must be 0 or 1");
    end

    uart_tx_state_t                state_q;
    uart_tx_state_t                state_d;
    uart_byte_t                    shift_q;
    uart_byte_t                    shift_d;
    logic [UART_BIT_IDX_W-1:0]     bit_idx_q;
    logic [UART_BIT_IDX_W-1:0]     bit_idx_d;
    logic                          txd_q;
    logic                          txd_d;
    logic                          busy_q;
    logic                          busy_d;
    logic                          ready_q;
    logic                          ready_d;
`ifdef UART_TX_PARITY_EN
    logic                          parity_q;
    logic                          parity_d;
`endif

    logic handshake;
    logic tick;

    // Ready is a pure flop, so it never depends combinationally on input_valid.
    assign handshake         = in_if.input_valid && ready_q;
    assign in_if.input_ready = ready_q;
    assign txd               = txd_q;
    assign busy              = busy_q;

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clock  (clock),
        .reset  (reset),
        .clear  (handshake),
        .enable (state_q != IDLE),
        .tick   (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        txd_d     = txd_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        unique case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (handshake) begin
                    shift_d   = in_if.input_data;
                    bit_idx_d = '0;
                    txd_d     = 1'b0;
                    state_d   = START;
`ifdef UART_TX_PARITY_EN
                    parity_d  = (^in_if.input_data) ^ 1'(PARITY_ODD);
`endif
                end
            end

            START: begin
                if (tick) begin
                    txd_d   = shift_q[0];
                    state_d = DATA;
                end
            end

            // The next bit to send is always shift_q[1] before the shift lands.
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == DATA_LAST) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        txd_d     = parity_q;
                        state_d   = PARITY;
`else
                        txd_d     = 1'b1;
                        state_d   = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + UART_BIT_IDX_W'(1);
                        txd_d     = shift_q[1];
                    end
                end
            end

            PARITY: begin
`ifdef UART_TX_PARITY_EN
                if (tick) begin
                    txd_d   = 1'b1;
                    state_d = STOP;
                end
`else
                txd_d   = 1'b1;
                state_d = IDLE;
`endif
            end

            // bit_idx counts stop-bit periods here.
            STOP: begin
                if (tick) begin
                    if (bit_idx_q == STOP_LAST) begin
                        bit_idx_d = '0;
                        txd_d     = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + UART_BIT_IDX_W'(1);
                    end
                end
            end

            default: begin
                txd_d   = 1'b1;
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Self-checking bench for uart_tx_stream: a frame-level model plus directed scenarios.
// Two instances share the stimulus: A is 8x1 even, B is 8x2 odd (parity only with UART_TX_PARITY_EN).
module tb_uart_tx_stream;

    localparam int C = 10;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
    localparam logic [15:0] EXP_55     = 16'h04AA;
    localparam int          EXP_LEN_A  = 110;
    localparam int          EXP_LEN_B  = 120;
    localparam int          EXP_SP     = 111;
    localparam logic        EXP_B_BIT9 = 1'b0;
`else
    localparam int P = 0;
    localparam logic [15:0] EXP_55     = 16'h02AA;
    localparam int          EXP_LEN_A  = 100;
    localparam int          EXP_LEN_B  = 110;
    localparam int          EXP_SP     = 101;
    localparam logic        EXP_B_BIT9 = 1'b1;
`endif
    localparam int          NS      = 10 + P;
    localparam logic [15:0] NS_MASK = 16'((1 << NS) - 1);

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       txd_a, busy_a, txd_b, busy_b;
    bit         chk_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    uart_tx_stream_if if_a ();
    uart_tx_stream_if if_b ();
    assign if_a.input_valid = valid;
    assign if_a.input_data  = data;
    assign if_b.input_valid = valid;
    assign if_b.input_data  = data;

    uart_tx_stream #(.CLOCK_HZ(1_000_000), .BAUD_RATE(100_000), .STOP_BITS(1), .PARITY_ODD(0))
        dut_a (.clock(clock), .reset(reset), .in_if(if_a), .txd(txd_a), .busy(busy_a));
    uart_tx_stream #(.CLOCK_HZ(1_000_000), .BAUD_RATE(100_000), .STOP_BITS(2), .PARITY_ODD(1))
        dut_b (.clock(clock), .reset(reset), .in_if(if_b), .txd(txd_b), .busy(busy_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    // ---------------- frame-level model ----------------
    int unsigned cyc = 0;
    bit          m_active [2] = '{1'b0, 1'b0};
    bit          m_ready  [2] = '{1'b0, 1'b0};
    int          m_el     [2];
    int          m_len    [2];
    logic [15:0] m_bits   [2];
    int          hs_cnt   [2];
    int          hs_prev  [2];
    int          hs_last  [2];

    function automatic logic [15:0] build_frame(input logic [7:0] d, input bit odd);
        logic [15:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = d[i];
        if (P == 1) f[9] = (^d) ^ odd;
        return f;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_active[i] = 1'b0;
                m_ready[i]  = 1'b0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (m_ready[i] && valid) begin
                    m_active[i] = 1'b1;
                    m_ready[i]  = 1'b0;
                    m_el[i]     = 0;
                    m_bits[i]   = build_frame(data, (i == 1));
                    m_len[i]    = (9 + P + i + 1) * C;
                    hs_cnt[i]++;
                    hs_prev[i]  = hs_last[i];
                    hs_last[i]  = int'(cyc);
                end else if (m_active[i]) begin
                    m_el[i]++;
                    if (m_el[i] == m_len[i]) begin
                        m_active[i] = 1'b0;
                        m_ready[i]  = 1'b1;
                    end
                end else begin
                    m_ready[i] = 1'b1;
                end
            end
        end
    end

    function automatic logic cur_txd(input bit sel);
        return sel ? txd_b : txd_a;
    endfunction

    function automatic logic cur_ready(input bit sel);
        return sel ? if_b.input_ready : if_a.input_ready;
    endfunction

    function automatic logic cur_busy(input bit sel);
        return sel ? busy_b : busy_a;
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic exp_txd;
                exp_txd = m_active[i] ? m_bits[i][m_el[i] / C] : 1'b1;
                check($sformatf("txd[%0d] cyc %0d", i, cyc), 32'(cur_txd(i == 1)), 32'(exp_txd));
                check($sformatf("busy[%0d] cyc %0d", i, cyc), 32'(cur_busy(i == 1)), 32'(m_active[i]));
                check($sformatf("ready[%0d] cyc %0d", i, cyc), 32'(cur_ready(i == 1)), 32'(m_ready[i]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        while (!(m_ready[0] && m_ready[1]) && n < 1000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 1000) timeout("wait_idle");
        @(negedge clock);
    endtask

    // Returns one cycle into the start bit (t=0) with valid already dropped.
    task automatic send(input logic [7:0] d);
        int n;
        int base;
        wait_idle();
        @(negedge clock);
        #1;
        data  = d;
        valid = 1'b1;
        base  = hs_cnt[0];
        n     = 0;
        do begin
            @(negedge clock);
            n++;
        end while (hs_cnt[0] == base && n < 50);
        if (n >= 50) timeout("send_handshake");
        #1;
        valid = 1'b0;
    endtask

    // Samples start, data, [parity] and first stop bit at each bit centre.
    task automatic rx(input bit sel, output logic [15:0] samp);
        int n;
        samp = '1;
        n    = 0;
        while (cur_txd(sel) !== 1'b0 && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (n >= 400) begin
            timeout("rx_start");
        end else begin
            repeat (5) @(negedge clock);
            for (int b = 0; b < NS; b++) begin
                samp[b] = cur_txd(sel);
                if (b < NS - 1) repeat (C) @(negedge clock);
            end
        end
    endtask

    task automatic ready_time(input bit sel, output int n);
        n = 0;
        while (cur_ready(sel) !== 1'b1 && n < 400) begin
            @(negedge clock);
            n++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s, s1, s2, sa, sb;
        int          na, nb, base0, base1, n;

        // Reset state and release.
        #1;
        reset  = 1'b1;
        chk_en = 1'b1;
        #1;
        check("rst_txd", 32'(txd_a), 32'd1);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_ready", 32'(if_a.input_ready), 32'd0);
        repeat (3) @(negedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_release_a", 32'(if_a.input_ready), 32'd1);
        check("ready_after_release_b", 32'(if_b.input_ready), 32'd1);

        // Single byte 0x55.
        send(8'h55);
        fork
            rx(1'b0, s);
            ready_time(1'b0, na);
        join
        check("t2_bits_55", 32'(s & NS_MASK), 32'(EXP_55));
        check("t2_ready_time", 32'(na), 32'(EXP_LEN_A));

        // Back-to-back 0xA3, 0x0F with valid held.
        wait_idle();
        @(negedge clock);
        #1;
        data  = 8'hA3;
        valid = 1'b1;
        base0 = hs_cnt[0];
        base1 = hs_cnt[1];
        n     = 0;
        while (hs_cnt[0] == base0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) timeout("t3_first_handshake");
        #1;
        data = 8'h0F;
        fork
            begin
                rx(1'b0, s1);
                rx(1'b0, s2);
            end
            begin
                int m;
                m = 0;
                while (!(hs_cnt[0] >= base0 + 2 && hs_cnt[1] >= base1 + 2) && m < 500) begin
                    @(negedge clock);
                    m++;
                end
                if (m >= 500) timeout("t3_second_handshake");
                #1;
                valid = 1'b0;
            end
        join
        check("t3_spacing", 32'(hs_last[0] - hs_prev[0]), 32'(EXP_SP));
        check("t3_byte0", 32'(s1[8:1]), 32'h0A3);
        check("t3_start0", 32'(s1[0]), 32'd0);
        check("t3_stop0", 32'(s1[NS-1]), 32'd1);
        check("t3_byte1", 32'(s2[8:1]), 32'h00F);
        check("t3_stop1", 32'(s2[NS-1]), 32'd1);

        // 0x07 on both instances: parity polarity and frame length.
        send(8'h07);
        fork
            rx(1'b0, sa);
            rx(1'b1, sb);
            ready_time(1'b0, na);
            ready_time(1'b1, nb);
        join
        check("t4_byte_a", 32'(sa[8:1]), 32'h007);
        check("t4_byte_b", 32'(sb[8:1]), 32'h007);
        check("t4_bit9_a", 32'(sa[9]), 32'd1);
        check("t4_bit9_b", 32'(sb[9]), 32'(EXP_B_BIT9));
        check("t4_len_a", 32'(na), 32'(EXP_LEN_A));
        check("t4_len_b", 32'(nb), 32'(EXP_LEN_B));

        // Mid-frame data change and valid pulse are ignored.
        send(8'h3C);
        base0 = hs_cnt[0];
        base1 = hs_cnt[1];
        fork
            rx(1'b0, s);
            begin
                repeat (30) @(negedge clock);
                #1;
                data  = 8'hFF;
                valid = 1'b1;
                @(negedge clock);
                #1;
                valid = 1'b0;
            end
        join
        wait_idle();
        check("t5_no_extra_hs_a", 32'(hs_cnt[0]), 32'(base0));
        check("t5_no_extra_hs_b", 32'(hs_cnt[1]), 32'(base1));
        check("t5_byte", 32'(s[8:1]), 32'h03C);

        // Reset in the middle of a 0x00 frame, then a fresh 0x81.
        send(8'h00);
        repeat (35) @(negedge clock);
        check("t6_txd_low_before_reset", 32'(txd_a), 32'd0);
        #1;
        reset = 1'b1;
        #1;
        check("t6_txd_async_high", 32'(txd_a), 32'd1);
        check("t6_busy_cleared", 32'(busy_a), 32'd0);
        check("t6_ready_in_reset", 32'(if_a.input_ready), 32'd0);
        repeat (2) @(negedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("t6_ready_after_release", 32'(if_a.input_ready), 32'd1);
        send(8'h81);
        rx(1'b0, s);
        check("t6_byte_81", 32'(s[8:1]), 32'h081);
        check("t6_stop_81", 32'(s[NS-1]), 32'd1);

        wait_idle();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
